// File: rtl/cci_test_fiu_throttle.sv
// cci_test_fiu_throttle: per-channel FIU in-flight line tracker driving forced almost-full with slack and hysteresis.
module cci_test_fiu_throttle_chan #(
    parameter int CNT_W       = 10,
    parameter int SLACK_LINES = 8,
    parameter int HYST_LINES  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       inc,
    input  logic [2:0]       dec,
    input  logic             limit_en,
    input  logic [CNT_W-1:0] limit,
    input  logic             clear_stats,
    output logic             force_af,
    output logic [CNT_W-1:0] active,
    output logic [CNT_W-1:0] peak,
    output logic             err_uf,
    output logic             err_of
);
    localparam int W = CNT_W + 2;
    localparam logic [W-1:0] MAXV = W'((1 << CNT_W) - 1);
    typedef enum logic {OPEN, THROTTLE} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, peak_q, peak_d;
    logic err_uf_q, err_uf_d, err_of_q, err_of_d;
    logic [W-1:0] nxt, lvl, lim_w;
    logic uf, of;
    // Two guard bits keep cur+inc-dec exact; the top bit doubles as the sign.
    always_comb begin
        nxt      = {2'b00, cnt_q} + W'(inc) - W'(dec);
        uf       = nxt[W-1];
        of       = !uf && (nxt > MAXV);
        cnt_d    = uf ? '0 : (of ? '1 : nxt[CNT_W-1:0]);
        lvl      = {2'b00, cnt_d} + W'(SLACK_LINES);
        lim_w    = {2'b00, limit};
        state_d  = state_q;
        if (state_q == OPEN && limit_en && lvl >= lim_w)
            state_d = THROTTLE;
        else if (state_q == THROTTLE && (!limit_en || (lvl + W'(HYST_LINES)) < lim_w))
            state_d = OPEN;
        peak_d   = (clear_stats || cnt_d > peak_q) ? cnt_d : peak_q;
        err_uf_d = uf || (err_uf_q && !clear_stats);
        err_of_d = of || (err_of_q && !clear_stats);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= OPEN;
            cnt_q    <= '0;
            peak_q   <= '0;
            err_uf_q <= 1'b0;
            err_of_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            peak_q   <= peak_d;
            err_uf_q <= err_uf_d;
            err_of_q <= err_of_d;
        end
    end
    assign force_af = (state_q == THROTTLE);
    assign active   = cnt_q;
    assign peak     = peak_q;
    assign err_uf   = err_uf_q;
    assign err_of   = err_of_q;
endmodule

module cci_test_fiu_throttle #(
    parameter int MAX_ACTIVE_LINES = 512,
    parameter int SLACK_LINES      = 8,
    parameter int HYST_LINES       = 4,
    parameter int CNT_W            = $clog2(MAX_ACTIVE_LINES) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             c0_req_valid,
    input  logic [1:0]       c0_req_cl_len,
    input  logic             c0_rsp_valid,
    input  logic             c1_req_valid,
    input  logic             c1_rsp_valid,
    input  logic             c1_rsp_packed,
    input  logic [1:0]       c1_rsp_cl_num,
    input  logic             limit_en,
    input  logic [CNT_W-1:0] c0_limit,
    input  logic [CNT_W-1:0] c1_limit,
    input  logic             clear_stats,
    output logic             c0_force_almost_full,
    output logic             c1_force_almost_full,
    output logic [CNT_W-1:0] c0_active_lines,
    output logic [CNT_W-1:0] c1_active_lines,
    output logic [CNT_W-1:0] c0_peak_lines,
    output logic [CNT_W-1:0] c1_peak_lines,
    output logic [1:0]       err_underflow,
    output logic [1:0]       err_overflow
);
    logic [2:0] c0_inc, c0_dec, c1_inc, c1_dec;
    always_comb begin
        c0_inc = c0_req_valid ? {1'b0, c0_req_cl_len} + 3'd1 : 3'd0;
        c0_dec = {2'b00, c0_rsp_valid};
        c1_inc = {2'b00, c1_req_valid};
        c1_dec = c1_rsp_valid ? (c1_rsp_packed ? {1'b0, c1_rsp_cl_num} + 3'd1 : 3'd1) : 3'd0;
    end
    cci_test_fiu_throttle_chan #(.CNT_W(CNT_W), .SLACK_LINES(SLACK_LINES), .HYST_LINES(HYST_LINES)) u_c0 (
        .clk(clk), .reset_n(reset_n), .inc(c0_inc), .dec(c0_dec),
        .limit_en(limit_en), .limit(c0_limit), .clear_stats(clear_stats),
        .force_af(c0_force_almost_full), .active(c0_active_lines), .peak(c0_peak_lines),
        .err_uf(err_underflow[0]), .err_of(err_overflow[0])
    );
    cci_test_fiu_throttle_chan #(.CNT_W(CNT_W), .SLACK_LINES(SLACK_LINES), .HYST_LINES(HYST_LINES)) u_c1 (
        .clk(clk), .reset_n(reset_n), .inc(c1_inc), .dec(c1_dec),
        .limit_en(limit_en), .limit(c1_limit), .clear_stats(clear_stats),
        .force_af(c1_force_almost_full), .active(c1_active_lines), .peak(c1_peak_lines),
        .err_uf(err_underflow[1]), .err_of(err_overflow[1])
    );
endmodule

// File: tb/tb_cci_test_fiu_throttle.sv
// tb_cci_test_fiu_throttle: scoreboard bench with a line-count reference model for cci_test_fiu_throttle.
module tb_cci_test_fiu_throttle;
    localparam int CW = 10;
    localparam int MAXC = (1 << CW) - 1;
    localparam int SLACK = 8;
    localparam int HYST = 4;

    logic clk = 0, reset_n = 0;
    logic c0_req_valid = 0, c0_rsp_valid = 0, c1_req_valid = 0, c1_rsp_valid = 0, c1_rsp_packed = 0;
    logic [1:0] c0_req_cl_len = 0, c1_rsp_cl_num = 0;
    logic limit_en = 0, clear_stats = 0;
    logic [CW-1:0] c0_limit = 0, c1_limit = 0;
    logic c0_force_almost_full, c1_force_almost_full;
    logic [CW-1:0] c0_active_lines, c1_active_lines, c0_peak_lines, c1_peak_lines;
    logic [1:0] err_underflow, err_overflow;

    cci_test_fiu_throttle dut (
        .clk(clk), .reset_n(reset_n),
        .c0_req_valid(c0_req_valid), .c0_req_cl_len(c0_req_cl_len), .c0_rsp_valid(c0_rsp_valid),
        .c1_req_valid(c1_req_valid), .c1_rsp_valid(c1_rsp_valid), .c1_rsp_packed(c1_rsp_packed),
        .c1_rsp_cl_num(c1_rsp_cl_num), .limit_en(limit_en), .c0_limit(c0_limit), .c1_limit(c1_limit),
        .clear_stats(clear_stats), .c0_force_almost_full(c0_force_almost_full),
        .c1_force_almost_full(c1_force_almost_full), .c0_active_lines(c0_active_lines),
        .c1_active_lines(c1_active_lines), .c0_peak_lines(c0_peak_lines), .c1_peak_lines(c1_peak_lines),
        .err_underflow(err_underflow), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int f0, f1, a0, a1, p0, p1, uf, of;
    } exp_t;
    exp_t sb[$];
    int tests = 0, fails = 0;

    // Reference model state: plain integer line counts per channel.
    int cnt[2], peak[2], thr[2], ue[2], oe[2];
    bit cfg_en = 0, cfg_cl = 0;
    int cfg_l0 = 0, cfg_l1 = 0;

    task automatic chk(input string n, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d at %0t", n, act, req, $time);
        end
    endtask

    task automatic mdl(input int ch, input int inc, input int dec, input int lim);
        int n;
        n = cnt[ch] + inc - dec;
        ue[ch] = cfg_cl ? 0 : ue[ch];
        oe[ch] = cfg_cl ? 0 : oe[ch];
        if (n < 0) begin n = 0; ue[ch] = 1; end
        if (n > MAXC) begin n = MAXC; oe[ch] = 1; end
        cnt[ch] = n;
        peak[ch] = (cfg_cl || n > peak[ch]) ? n : peak[ch];
        if (thr[ch] == 0 && cfg_en && n + SLACK >= lim) thr[ch] = 1;
        else if (thr[ch] == 1 && (!cfg_en || n + SLACK + HYST < lim)) thr[ch] = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0; peak[i] = 0; thr[i] = 0; ue[i] = 0; oe[i] = 0;
        end
    endtask

    task automatic step(input bit r0v, input int r0l, input bit s0v, input bit w1v,
                        input bit s1v, input bit pk, input int cn);
        exp_t e;
        @(negedge clk);
        c0_req_valid = r0v; c0_req_cl_len = 2'(r0l); c0_rsp_valid = s0v;
        c1_req_valid = w1v; c1_rsp_valid = s1v; c1_rsp_packed = pk; c1_rsp_cl_num = 2'(cn);
        limit_en = cfg_en; c0_limit = CW'(cfg_l0); c1_limit = CW'(cfg_l1); clear_stats = cfg_cl;
        mdl(0, r0v ? r0l + 1 : 0, s0v ? 1 : 0, cfg_l0);
        mdl(1, w1v ? 1 : 0, s1v ? (pk ? cn + 1 : 1) : 0, cfg_l1);
        e.f0 = thr[0]; e.f1 = thr[1]; e.a0 = cnt[0]; e.a1 = cnt[1];
        e.p0 = peak[0]; e.p1 = peak[1];
        e.uf = ue[1] * 2 + ue[0]; e.of = oe[1] * 2 + oe[0];
        sb.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("c0_force", int'(c0_force_almost_full), e.f0);
                chk("c1_force", int'(c1_force_almost_full), e.f1);
                chk("c0_active", int'(c0_active_lines), e.a0);
                chk("c1_active", int'(c1_active_lines), e.a1);
                chk("c0_peak", int'(c0_peak_lines), e.p0);
                chk("c1_peak", int'(c1_peak_lines), e.p1);
                chk("err_underflow", int'(err_underflow), e.uf);
                chk("err_overflow", int'(err_overflow), e.of);
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("reset_c0_active", int'(c0_active_lines), 0);
        chk("reset_c0_force", int'(c0_force_almost_full), 0);
        @(negedge clk) reset_n = 1;
        cfg_en = 1; cfg_l0 = 20; cfg_l1 = 100;
        repeat (5) step(1, 3, 0, 0, 0, 0, 0);
        repeat (15) step(0, 0, 1, 0, 0, 0, 0);
        step(1, 3, 1, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 3);
        step(0, 0, 0, 0, 1, 0, 0);
        repeat (5) step(1, 3, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        idle();
        cfg_en = 0;
        idle();
        idle();
        repeat (24) step(0, 0, 1, 0, 0, 0, 0);
        cfg_cl = 1;
        idle();
        cfg_cl = 0;
        idle();
        cfg_en = 1; cfg_l0 = 5;
        repeat (3) step(0, 0, 1, 0, 0, 0, 0);
        repeat (4) step(0, 0, 1, 0, 0, 0, 0);
        cfg_en = 0;
        repeat (260) step(1, 3, 0, 0, 0, 0, 0);
        cfg_en = 1; cfg_l0 = 100;
        idle();
        step(1, 3, 0, 1, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("queue_drained", sb.size(), 0);
        reset_n = 0;
        c0_req_valid = 0; c1_req_valid = 0;
        #1;
        chk("async_c0_active", int'(c0_active_lines), 0);
        chk("async_c0_force", int'(c0_force_almost_full), 0);
        chk("async_c0_peak", int'(c0_peak_lines), 0);
        chk("async_err_of", int'(err_overflow), 0);
        model_reset();
        @(negedge clk) reset_n = 1;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                cfg_en = ($urandom_range(0, 3) != 0);
                cfg_l0 = $urandom_range(0, 40);
                cfg_l1 = $urandom_range(0, 40);
            end
            cfg_cl = ($urandom_range(0, 63) == 0);
            step($urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 1) == 0,
                 $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 0, $urandom_range(0, 3));
        end
        cfg_cl = 0;
        @(posedge clk);
        #2;
        chk("final_queue_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
